// File: rtl/onehot_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : onehot_arb_mux
// Purpose  : N-channel valid/ready arbiter feeding a one-hot payload mux and
//            a single-entry registered output stage. Grant is generated
//            internally by round-robin (MODE=0) or by fixed lowest-index
//            priority (MODE=1). With LOCK_ON_LAST=1 a grant is held for a
//            whole burst, until a beat flagged last is accepted.
// Ports    : clock, reset   - rising-edge clock, async active-high reset
//            in_valid/in_ready/in_data/in_last - N request channels
//            out_valid/out_ready/out_data/out_last - registered output beat
//            out_sel/out_idx - one-hot and binary source of the output beat
// Revision : 1.0 - initial release
// ============================================================================
module onehot_arb_mux #(
    parameter int N            = 4,
    parameter int WIDTH        = 32,
    parameter int MODE         = 0,
    parameter int LOCK_ON_LAST = 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [N-1:0]                        in_valid,
    output logic [N-1:0]                        in_ready,
    input  logic [WIDTH-1:0]                    in_data [N],
    input  logic [N-1:0]                        in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    out_data,
    output logic                                out_last,
    output logic [N-1:0]                        out_sel,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_idx
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Output stage registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;
    logic [N-1:0]     out_sel_q,   out_sel_d;
    logic [IW-1:0]    out_idx_q,   out_idx_d;

    // Arbitration state
    logic             lock_q,     lock_d;
    logic [IW-1:0]    lock_idx_q, lock_idx_d;
    logic [IW-1:0]    ptr_q,      ptr_d;

    // Combinational arbitration results
    logic [N-1:0]     grant;
    logic [IW-1:0]    gidx;
    logic             gvalid;
    logic             free;
    logic             accept;

    // The stage can take a new beat when empty or when its beat leaves now.
    assign free   = !out_valid_q || out_ready;
    assign accept = gvalid && free && !reset;

    // in_ready depends only on in_valid, out_ready and state.
    assign in_ready = (reset || !free) ? '0 : grant;

    // ------------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------------
    always_comb begin
        logic [IW-1:0] cand;
        int            j;
        grant  = '0;
        gidx   = '0;
        gvalid = 1'b0;
        cand   = '0;
        j      = 0;
        if (lock_q) begin
            // Mid-burst: only the locked channel may proceed; if it is idle
            // this cycle the others still wait (bubble).
            if (in_valid[lock_idx_q]) begin
                gidx   = lock_idx_q;
                gvalid = 1'b1;
            end
        end else if (MODE == 1) begin
            for (int i = 0; i < N; i++) begin
                cand = IW'(i);
                if (!gvalid && in_valid[cand]) begin
                    gidx   = cand;
                    gvalid = 1'b1;
                end
            end
        end else begin
            // Scan upward from the pointer, wrapping N-1 -> 0.
            for (int k = 0; k < N; k++) begin
                j = int'(ptr_q) + k;
                if (j >= N) begin
                    j = j - N;
                end
                cand = IW'(j);
                if (!gvalid && in_valid[cand]) begin
                    gidx   = cand;
                    gvalid = 1'b1;
                end
            end
        end
        if (gvalid) begin
            grant[gidx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        out_idx_d   = out_idx_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        ptr_d       = ptr_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[gidx];
            out_last_d  = in_last[gidx];
            out_sel_d   = grant;
            out_idx_d   = gidx;

            if (LOCK_ON_LAST != 0) begin
                lock_d     = !in_last[gidx];
                lock_idx_d = gidx;
            end

            // Pointer only advances once the channel releases the output;
            // during a burst the lock, not the pointer, selects the source.
            if (!lock_d) begin
                ptr_d = (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
            end
        end else if (out_ready) begin
            // Beat consumed with nothing behind it; payload left as is.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
            out_idx_q   <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
            out_idx_q   <= out_idx_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    assign out_idx   = out_idx_q;

endmodule
`default_nettype wire
